// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and load/store.
// Define MEM_ARB_TIMEOUT_EN to abort a memory access that stalls in WAIT for TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_be_o,
  input  logic                m_ack_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                grantData_q, grantData_d;
  logic                lastGrantData_q, lastGrantData_d;
  logic                ifAck_q, ifAck_d;
  logic                dAck_q, dAck_d;
  logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0]   dRdata_q, dRdata_d;
  logic                mReq_q, mReq_d;
  logic                mWe_q, mWe_d;
  logic [ADDR_W-1:0]   mAddr_q, mAddr_d;
  logic [DATA_W-1:0]   mWdata_q, mWdata_d;
  logic [BE_W-1:0]     mBe_q, mBe_d;
  logic                busy_q, busy_d;
  logic                err_d;

  logic                pickData;
  logic                finish;
  logic [DATA_W-1:0]   respData;
  logic                respErr;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             err_q;
`endif

  always_comb begin
    state_d         = state_q;
    grantData_d     = grantData_q;
    lastGrantData_d = lastGrantData_q;
    ifAck_d         = 1'b0;
    dAck_d          = 1'b0;
    ifRdata_d       = ifRdata_q;
    dRdata_d        = dRdata_q;
    mReq_d          = mReq_q;
    mWe_d           = mWe_q;
    mAddr_d         = mAddr_q;
    mWdata_d        = mWdata_q;
    mBe_d           = mBe_q;
    busy_d          = busy_q;
    err_d           = 1'b0;
    pickData        = 1'b0;
    finish          = 1'b0;
    respData        = '0;
    respErr         = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    waitCnt_d       = waitCnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          // On a tie the port that did not win last time gets the memory
          pickData        = d_req_i && (!if_req_i || !lastGrantData_q);
          grantData_d     = pickData;
          lastGrantData_d = pickData;
          mReq_d          = 1'b1;
          busy_d          = 1'b1;
          state_d         = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          waitCnt_d       = '0;
`endif
          if (pickData) begin
            mWe_d    = d_we_i;
            mAddr_d  = d_addr_i;
            mWdata_d = d_wdata_i;
            mBe_d    = d_be_i;
          end else begin
            mWe_d    = 1'b0;
            mAddr_d  = if_addr_i;
            mWdata_d = '0;
            mBe_d    = {BE_W{1'b1}};
          end
        end
      end

      WAIT: begin
        if (m_ack_i) begin
          finish   = 1'b1;
          respData = mWe_q ? '0 : m_rdata_i;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (waitCnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          finish  = 1'b1;
          respErr = 1'b1;
        end else if (waitCnt_q != {CNT_W{1'b1}}) begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
`endif
        if (finish) begin
          mReq_d  = 1'b0;
          err_d   = respErr;
          state_d = RESP;
          if (grantData_q) begin
            dAck_d   = 1'b1;
            dRdata_d = respData;
          end else begin
            ifAck_d   = 1'b1;
            ifRdata_d = respData;
          end
        end
      end

      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        mReq_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any in-flight access; last grant starts at fetch so the first tie favours data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      grantData_q     <= 1'b0;
      lastGrantData_q <= 1'b0;
      ifAck_q         <= 1'b0;
      dAck_q          <= 1'b0;
      ifRdata_q       <= '0;
      dRdata_q        <= '0;
      mReq_q          <= 1'b0;
      mWe_q           <= 1'b0;
      mAddr_q         <= '0;
      mWdata_q        <= '0;
      mBe_q           <= '0;
      busy_q          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      waitCnt_q       <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      grantData_q     <= grantData_d;
      lastGrantData_q <= lastGrantData_d;
      ifAck_q         <= ifAck_d;
      dAck_q          <= dAck_d;
      ifRdata_q       <= ifRdata_d;
      dRdata_q        <= dRdata_d;
      mReq_q          <= mReq_d;
      mWe_q           <= mWe_d;
      mAddr_q         <= mAddr_d;
      mWdata_q        <= mWdata_d;
      mBe_q           <= mBe_d;
      busy_q          <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      waitCnt_q       <= waitCnt_d;
      err_q           <= err_d;
`endif
    end
  end

  assign if_ack_o   = ifAck_q;
  assign if_rdata_o = ifRdata_q;
  assign d_ack_o    = dAck_q;
  assign d_rdata_o  = dRdata_q;
  assign m_req_o    = mReq_q;
  assign m_we_o     = mWe_q;
  assign m_addr_o   = mAddr_q;
  assign m_wdata_o  = mWdata_q;
  assign m_be_o     = mBe_q;
  assign busy_o     = busy_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  // Without the timeout path no access can be aborted, so err is constant 0
  assign err_o = (TIMEOUT_CYCLES < 0) && err_d;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model answers m_req,
// each test pushes expected completions and pops them when an ack appears.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ifReq = 1'b0;
  logic [ADDR_W-1:0] ifAddr = '0;
  logic              ifAck;
  logic [DATA_W-1:0] ifRdata;
  logic              dReq = 1'b0;
  logic              dWe = 1'b0;
  logic [ADDR_W-1:0] dAddr = '0;
  logic [DATA_W-1:0] dWdata = '0;
  logic [BE_W-1:0]   dBe = '0;
  logic              dAck;
  logic [DATA_W-1:0] dRdata;
  logic              mReq;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata;
  logic [BE_W-1:0]   mBe;
  logic              mAck = 1'b0;
  logic [DATA_W-1:0] mRdata = '0;
  logic              busy;
  logic              err;

  typedef struct packed {
    logic              isData;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   memDelay = 0;
  bit   memNever = 1'b0;
  int   memCnt = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .if_req_i(ifReq),
    .if_addr_i(ifAddr),
    .if_ack_o(ifAck),
    .if_rdata_o(ifRdata),
    .d_req_i(dReq),
    .d_we_i(dWe),
    .d_addr_i(dAddr),
    .d_wdata_i(dWdata),
    .d_be_i(dBe),
    .d_ack_o(dAck),
    .d_rdata_o(dRdata),
    .m_req_o(mReq),
    .m_we_o(mWe),
    .m_addr_o(mAddr),
    .m_wdata_o(mWdata),
    .m_be_o(mBe),
    .m_ack_i(mAck),
    .m_rdata_i(mRdata),
    .busy_o(busy),
    .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] memFn(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: acks after memDelay waiting cycles, one-cycle m_ack pulse
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mAck   = 1'b0;
      memCnt = 0;
    end else if (mAck) begin
      mAck   = 1'b0;
      memCnt = 0;
    end else if (mReq && !memNever) begin
      if (memCnt >= memDelay) begin
        mAck   = 1'b1;
        mRdata = memFn(mAddr);
        memCnt = 0;
      end else begin
        memCnt++;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; ifReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({mReq, ifAck, dAck, busy, err, mWe} !== 6'b0) begin errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000000", {mReq, ifAck, dAck, busy, err, mWe}); end
    checks++; if ({ifRdata, dRdata} !== 64'h0) begin errors++;
      $display("[TB] FAIL reset_rdata got=%h exp=0", {ifRdata, dRdata}); end
    checks++; if ({mAddr, mWdata, mBe} !== 68'h0) begin errors++;
      $display("[TB] FAIL reset_mfields got=%h exp=0", {mAddr, mWdata, mBe}); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    bit   got;
    int   reqCyc;
    memDelay = 0;
    @(negedge clk);
    sb.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0050_0093, 1'b0});
    ifAddr = 32'h100; ifReq = 1'b1; reqCyc = cyc;
    @(negedge clk);
    checks++; if ({mReq, busy} !== 2'b11) begin errors++;
      $display("[TB] FAIL fetch_mreq got=%b exp=11", {mReq, busy}); end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = ifAck | dAck; end
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("[TB] FAIL fetch_ack_timeout got=0 exp=1"); end
    checks++; if (cyc - reqCyc !== 2) begin errors++;
      $display("[TB] FAIL fetch_latency got=%0d exp=2", cyc - reqCyc); end
    checks++; if ({ifAck, dAck, err} !== {1'b1, 1'b0, e.err}) begin errors++;
      $display("[TB] FAIL fetch_ackflags got=%b exp=100", {ifAck, dAck, err}); end
    checks++; if (ifRdata !== e.rdata) begin errors++;
      $display("[TB] FAIL fetch_rdata got=%h exp=%h", ifRdata, e.rdata); end
    checks++; if ({mWe, mAddr, mWdata, mBe} !== {e.we, e.addr, e.wdata, e.be}) begin errors++;
      $display("[TB] FAIL fetch_mfields got=%h exp=%h", {mWe, mAddr, mWdata, mBe}, {e.we, e.addr, e.wdata, e.be}); end
    ifReq = 1'b0;
    @(negedge clk);
    checks++; if ({ifAck, busy} !== 2'b00) begin errors++;
      $display("[TB] FAIL fetch_after got=%b exp=00", {ifAck, busy}); end
  endtask

  task automatic test_store();
    exp_t e;
    bit   got;
    memDelay = 0;
    @(negedge clk);
    sb.push_back('{1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0});
    dAddr = 32'h200; dWe = 1'b1; dWdata = 32'hDEAD_BEEF; dBe = 4'b0011; dReq = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = ifAck | dAck; end
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("[TB] FAIL store_ack_timeout got=0 exp=1"); end
    checks++; if ({ifAck, dAck, err} !== {1'b0, 1'b1, e.err}) begin errors++;
      $display("[TB] FAIL store_ackflags got=%b exp=010", {ifAck, dAck, err}); end
    checks++; if (dRdata !== e.rdata) begin errors++;
      $display("[TB] FAIL store_rdata got=%h exp=%h", dRdata, e.rdata); end
    checks++; if ({mWe, mAddr, mWdata, mBe} !== {e.we, e.addr, e.wdata, e.be}) begin errors++;
      $display("[TB] FAIL store_mfields got=%h exp=%h", {mWe, mAddr, mWdata, mBe}, {e.we, e.addr, e.wdata, e.be}); end
    checks++; if (ifRdata !== 32'h0050_0093) begin errors++;
      $display("[TB] FAIL store_ifrdata_hold got=%h exp=00500093", ifRdata); end
    dReq = 1'b0; dWe = 1'b0;
    @(negedge clk);
    checks++; if (dAck !== 1'b0) begin errors++; $display("[TB] FAIL store_single_ack got=%b exp=0", dAck); end
  endtask

  task automatic test_tie_round_robin();
    exp_t e;
    bit   got;
    memDelay = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 4'b0101, 32'hA5A5_0300, 1'b0});
      else            sb.push_back('{1'b0, 1'b0, 32'h140, 32'h0, 4'hF, 32'hA5A5_0140, 1'b0});
    end
    dWe = 1'b0; dAddr = 32'h300; dBe = 4'b0101; ifAddr = 32'h140;
    dReq = 1'b1; ifReq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = ifAck | dAck; end
      e = sb.pop_front();
      checks++; if ({ifAck, dAck} !== {~e.isData, e.isData}) begin errors++;
        $display("[TB] FAIL tie_order_%0d got=%b exp=%b", k, {ifAck, dAck}, {~e.isData, e.isData}); end
      checks++; if ((e.isData ? dRdata : ifRdata) !== e.rdata || mAddr !== e.addr) begin errors++;
        $display("[TB] FAIL tie_data_%0d got=%h/%h exp=%h/%h", k, (e.isData ? dRdata : ifRdata), mAddr, e.rdata, e.addr); end
      if (dAck) dReq = 1'b0;
      if (ifAck) ifReq = 1'b0;
      if (k < 2) begin
        @(negedge clk);
        if (e.isData) dReq = 1'b1; else ifReq = 1'b1;
      end
    end
    dReq = 1'b0; ifReq = 1'b0;
  endtask

  task automatic test_long_wait();
    exp_t e;
    bit   got;
    int   extraAcks;
    logic [72:0] want;
    memDelay = 10;
    @(negedge clk);
    sb.push_back('{1'b1, 1'b1, 32'h404, 32'h1234_5678, 4'b1100, 32'h0, 1'b0});
    dAddr = 32'h404; dWe = 1'b1; dWdata = 32'h1234_5678; dBe = 4'b1100; dReq = 1'b1;
    want = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h404, 32'h1234_5678, 4'b1100};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({mReq, busy, ifAck, dAck, mWe, mAddr, mWdata, mBe} !== want) begin errors++;
        $display("[TB] FAIL wait_stable_%0d got=%h exp=%h", i, {mReq, busy, ifAck, dAck, mWe, mAddr, mWdata, mBe}, want); end
    end
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin @(negedge clk); got = ifAck | dAck; end
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("[TB] FAIL wait_ack_timeout got=0 exp=1"); end
    checks++; if ({dAck, err, mReq, dRdata} !== {1'b1, e.err, 1'b0, e.rdata}) begin errors++;
      $display("[TB] FAIL wait_resp got=%h exp=%h", {dAck, err, mReq, dRdata}, {1'b1, e.err, 1'b0, e.rdata}); end
    dReq = 1'b0; dWe = 1'b0;
    extraAcks = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (ifAck | dAck) extraAcks++; end
    checks++; if (extraAcks !== 0) begin errors++; $display("[TB] FAIL wait_single_ack got=%0d exp=0", extraAcks); end
    memDelay = 0;
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    bit   got;
    int   acks;
    memNever = 1'b1;
    @(negedge clk);
    ifAddr = 32'h500; ifReq = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({mReq, busy} !== 2'b11) begin errors++;
      $display("[TB] FAIL rstwait_pre got=%b exp=11", {mReq, busy}); end
    reset = 1'b1; ifReq = 1'b0;
    @(negedge clk);
    checks++; if ({mReq, busy, ifAck, dAck, ifRdata} !== 36'h0) begin errors++;
      $display("[TB] FAIL rstwait_post got=%h exp=0", {mReq, busy, ifAck, dAck, ifRdata}); end
    reset = 1'b0; memNever = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (ifAck | dAck | mReq) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL rstwait_quiet got=%0d exp=0", acks); end
    sb.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0050_0093, 1'b0});
    ifAddr = 32'h100; ifReq = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = ifAck | dAck; end
    e = sb.pop_front();
    checks++; if (!got || ifAck !== 1'b1 || ifRdata !== e.rdata) begin errors++;
      $display("[TB] FAIL rstwait_new got=%b/%h exp=1/%h", ifAck, ifRdata, e.rdata); end
    ifReq = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    bit   got;
    int   reqCycles;
    memNever = 1'b1;
    @(negedge clk);
    sb.push_back('{1'b0, 1'b0, 32'h700, 32'h0, 4'hF, 32'h0, 1'b1});
    ifAddr = 32'h700; ifReq = 1'b1;
    got = 1'b0; reqCycles = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = ifAck | dAck;
      if (!got && mReq) reqCycles++;
    end
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("[TB] FAIL timeout_ack got=0 exp=1"); end
    checks++; if (reqCycles !== 8) begin errors++; $display("[TB] FAIL timeout_len got=%0d exp=8", reqCycles); end
    checks++; if ({ifAck, err, mReq, ifRdata} !== {1'b1, e.err, 1'b0, e.rdata}) begin errors++;
      $display("[TB] FAIL timeout_resp got=%h exp=%h", {ifAck, err, mReq, ifRdata}, {1'b1, e.err, 1'b0, e.rdata}); end
    ifReq = 1'b0; memNever = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_pulse got=%b exp=0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_tie_round_robin();
    test_long_wait();
    test_reset_in_wait();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
